// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the script ROM data-port arbiter.
// Optional macro ROM_ARB_ALIGN_CHECK_EN enables misaligned-read errors.
package rom_arb_pkg;

   localparam int ROM_ADDR_W = 10;
   localparam int ROM_DATA_W = 32;
   localparam int ROM_DEPTH  = 256;

   typedef logic req_id_t;

   localparam req_id_t REQ_UART = 1'b0;
   localparam req_id_t REQ_REND = 1'b1;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   typedef enum logic {
      PREF_UART = 1'b0,
      PREF_REND = 1'b1
   } prio_t;

   function automatic logic misaligned(
      input logic [1:0] lsb
   );
      return |lsb;
   endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// One requester's read channel: req/addr/gnt plus rvalid/rdata response.
// master = requester side, slave = arbiter side; err only with ROM_ARB_ALIGN_CHECK_EN.
interface rom_port_arbiter_if
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W
) ();

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
`ifdef ROM_ARB_ALIGN_CHECK_EN
   logic              err;

   modport master (
      output req, addr,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr,
      output gnt, rvalid, rdata, err
   );
`else
   modport master (
      output req, addr,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr,
      output gnt, rvalid, rdata
   );
`endif

endinterface

// File: rtl/rom_arb_rr_picker.sv
// Two-way round-robin pick: clk, rst, req_u/req_r in, gnt_u/gnt_r out (comb).
// Pointer moves to the other requester only when a grant is actually given.
module rom_arb_rr_picker
   import rom_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_u,
   input  logic req_r,
   output logic gnt_u,
   output logic gnt_r
);

   prio_t ptr_q;
   prio_t ptr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= PREF_UART;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      gnt_u = 1'b0;
      gnt_r = 1'b0;
      ptr_d = ptr_q;
      if (!rst) begin
         unique case (1'b1)
            (req_u && req_r): begin
               gnt_u = (ptr_q == PREF_UART);
               gnt_r = (ptr_q == PREF_REND);
            end
            (req_u && !req_r): gnt_u = 1'b1;
            (!req_u && req_r): gnt_r = 1'b1;
            default: ;
         endcase
      end
      if (gnt_u) ptr_d = PREF_REND;
      if (gnt_r) ptr_d = PREF_UART;
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the script ROM data port between UART fetch and renderer reads.
// Ports: clk, rst, uart/rend (slave channels), rom_addr out, rom_data in.
// Grant->rvalid latency is fixed at 2; ROM_ARB_ALIGN_CHECK_EN adds err.
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   rom_port_arbiter_if.slave  uart,
   rom_port_arbiter_if.slave  rend,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [DATA_W-1:0]  rom_data
);

   logic              gnt_u;
   logic              gnt_r;
   logic              gnt_any;
   req_id_t           sel_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [ADDR_W-1:0] addr_q;
   tag_t              s1_q;
   logic [DATA_W-1:0] resp_data;
   logic              u_rv_q;
   logic              r_rv_q;
   logic [DATA_W-1:0] u_rd_q;
   logic [DATA_W-1:0] r_rd_q;

   rom_arb_rr_picker u_pick (
      .clk   (clk),
      .rst   (rst),
      .req_u (uart.req),
      .req_r (rend.req),
      .gnt_u (gnt_u),
      .gnt_r (gnt_r)
   );

   assign gnt_any  = gnt_u | gnt_r;
   assign sel_id   = gnt_r ? REQ_REND : REQ_UART;
   assign sel_addr = gnt_r ? rend.addr : uart.addr;

   // Idle cycles replay the last address; ROM reads have no side effects.
   assign rom_addr = gnt_any ? sel_addr : addr_q;

`ifdef ROM_ARB_ALIGN_CHECK_EN
   logic s1_mis_q;
   logic u_err_q;
   logic r_err_q;

   assign resp_data = s1_mis_q ? '0 : rom_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_mis_q <= 1'b0;
         u_err_q  <= 1'b0;
         r_err_q  <= 1'b0;
      end else begin
         s1_mis_q <= gnt_any && misaligned(sel_addr[1:0]);
         u_err_q  <= s1_q.valid && (s1_q.id == REQ_UART)
                     && s1_mis_q;
         r_err_q  <= s1_q.valid && (s1_q.id == REQ_REND)
                     && s1_mis_q;
      end
   end

   assign uart.err = u_err_q;
   assign rend.err = r_err_q;
`else
   assign resp_data = rom_data;
`endif

   // Stage 1 tag lines up with the ROM's own address register; the
   // data it returns next cycle is steered by that tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         s1_q   <= '0;
         u_rv_q <= 1'b0;
         r_rv_q <= 1'b0;
         u_rd_q <= '0;
         r_rd_q <= '0;
      end else begin
         if (gnt_any) addr_q <= sel_addr;
         s1_q.valid <= gnt_any;
         s1_q.id    <= sel_id;
         u_rv_q <= s1_q.valid && (s1_q.id == REQ_UART);
         r_rv_q <= s1_q.valid && (s1_q.id == REQ_REND);
         if (s1_q.valid && (s1_q.id == REQ_UART))
            u_rd_q <= resp_data;
         if (s1_q.valid && (s1_q.id == REQ_REND))
            r_rd_q <= resp_data;
      end
   end

   assign uart.gnt    = gnt_u;
   assign rend.gnt    = gnt_r;
   assign uart.rvalid = u_rv_q;
   assign rend.rvalid = r_rv_q;
   assign uart.rdata  = u_rd_q;
   assign rend.rdata  = r_rd_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a registered ROM model.
// Honours ROM_ARB_ALIGN_CHECK_EN for misaligned-read expectations.
module tb_rom_port_arbiter;
   import rom_arb_pkg::*;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] mem [256];

   exp_t        q [2][$];
   logic [31:0] last_d [2];
   logic [9:0]  last_a;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   rom_port_arbiter_if u_if ();
   rom_port_arbiter_if r_if ();

   rom_port_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .uart     (u_if.slave),
      .rend     (r_if.slave),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) rom_data <= mem[rom_addr[9:2]];

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic exp_err(logic [9:0] a);
`ifdef ROM_ARB_ALIGN_CHECK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_data(logic [9:0] a);
      if (exp_err(a)) return 32'h0;
      return mem[a[9:2]];
   endfunction

   task automatic mon(int i, logic rv, logic [31:0] rd,
                      logic e);
      string n;
      n = (i == 0) ? "uart" : "rend";
      if (q[i].size() != 0 && q[i][0].cyc < cyc) begin
         chk({n, "_missing_rvalid"}, 32'(rv), 32'd1);
         void'(q[i].pop_front());
      end
      if (rv) begin
         if (q[i].size() == 0) begin
            chk({n, "_spurious_rvalid"}, 32'(rv), 32'd0);
         end else begin
            exp_t x;
            x = q[i].pop_front();
            chk({n, "_latency"}, 32'(cyc), 32'(x.cyc));
            chk({n, "_rdata"}, rd, x.data);
            chk({n, "_err"}, 32'(e), 32'(x.err));
            last_d[i] = x.data;
         end
      end else begin
         chk({n, "_rdata_hold"}, rd, last_d[i]);
      end
   endtask

   always @(posedge clk) begin
      #2;
`ifdef ROM_ARB_ALIGN_CHECK_EN
      mon(0, u_if.rvalid, u_if.rdata, u_if.err);
      mon(1, r_if.rvalid, r_if.rdata, r_if.err);
`else
      mon(0, u_if.rvalid, u_if.rdata, 1'b0);
      mon(1, r_if.rvalid, r_if.rdata, 1'b0);
`endif
   end

   task automatic step(logic r, logic ur, logic [9:0] ua,
                       logic rr, logic [9:0] ra,
                       logic eu, logic er);
      @(negedge clk);
      rst        = r;
      u_if.req   = ur;
      u_if.addr  = ua;
      r_if.req   = rr;
      r_if.addr  = ra;
      if (r) begin
         q[0].delete();
         q[1].delete();
         last_d[0] = '0;
         last_d[1] = '0;
         last_a    = '0;
      end
      #1;
      chk("uart_gnt", 32'(u_if.gnt), 32'(eu));
      chk("rend_gnt", 32'(r_if.gnt), 32'(er));
      if (!r) begin
         if (eu) begin
            chk("rom_addr_u", 32'(rom_addr), 32'(ua));
            last_a = ua;
            q[0].push_back('{cyc + 2, exp_data(ua), exp_err(ua)});
         end else if (er) begin
            chk("rom_addr_r", 32'(rom_addr), 32'(ra));
            last_a = ra;
            q[1].push_back('{cyc + 2, exp_data(ra), exp_err(ra)});
         end else begin
            chk("rom_addr_hold", 32'(rom_addr), 32'(last_a));
         end
      end
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 1'b0);
   endtask

   task automatic do_rst();
      step(1'b1, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0001;
      mem[4]    = 32'hDEAD_BEEF;
      last_d[0] = '0;
      last_d[1] = '0;
      last_a    = '0;
      u_if.req  = 1'b0;
      u_if.addr = '0;
      r_if.req  = 1'b0;
      r_if.addr = '0;

      do_rst();
      do_rst();
      idle(2);

      // single read
      step(1'b0, 1'b1, 10'h010, 1'b0, 10'h0, 1'b1, 1'b0);
      idle(4);

      // contention from reset
      do_rst();
      for (int k = 0; k < 4; k++)
         step(1'b0, 1'b1, 10'h000, 1'b1, 10'h004,
              (k % 2) == 0, (k % 2) == 1);
      idle(4);

      // back-to-back renderer reads
      step(1'b0, 1'b0, 10'h0, 1'b1, 10'h008, 1'b0, 1'b1);
      step(1'b0, 1'b0, 10'h0, 1'b1, 10'h00C, 1'b0, 1'b1);
      step(1'b0, 1'b0, 10'h0, 1'b1, 10'h010, 1'b0, 1'b1);
      idle(5);

      // reset mid-flight
      step(1'b0, 1'b1, 10'h020, 1'b0, 10'h0, 1'b1, 1'b0);
      do_rst();
      idle(3);
      step(1'b0, 1'b1, 10'h030, 1'b1, 10'h034, 1'b1, 1'b0);
      idle(4);

      // withdrawn request keeps pointer
      do_rst();
      step(1'b0, 1'b0, 10'h0, 1'b1, 10'h00C, 1'b0, 1'b1);
      idle(1);
      step(1'b0, 1'b1, 10'h040, 1'b1, 10'h044, 1'b1, 1'b0);
      step(1'b0, 1'b1, 10'h040, 1'b1, 10'h044, 1'b0, 1'b1);
      idle(4);

      // misaligned address
      step(1'b0, 1'b1, 10'h006, 1'b0, 10'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 10'h0, 1'b1, 10'h00B, 1'b0, 1'b1);
      step(1'b0, 1'b1, 10'h014, 1'b0, 10'h0, 1'b1, 1'b0);
      idle(5);

      chk("uart_queue_empty", 32'(q[0].size()), 32'd0);
      chk("rend_queue_empty", 32'(q[1].size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
